writeback_port_arbiter: RTL and testbench
=========================================

// Module: writeback_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order stage-5 writeback
//  and a long-latency unit (mul/div), which returns results through a valid/ready handshake.
//  Stage 5 always has priority. Long-latency results wait in a DEPTH-entry FIFO and
//  drain into idle writeback slots.
//  Also flags read hazards against buffered results, and raises a stall request
//  when the FIFO is starved.
// PARAMETERS
//  DEPTH         4   FIFO entries; power of two, >= 2
//  STARVE_LIMIT  8   consecutive non-draining cycles with FIFO non-empty before stall_req
// PORTS
//  clock       in   1   sole clock; all state updates on rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  pipe_wr_en  in   1   stage-5 write request (valid & ~store & ~branch)
//  pipe_rd     in   5   stage-5 destination register
//  pipe_value  in   32  stage-5 writeback value
//  lu_valid    in   1   long-latency result valid
//  lu_ready    out  1   FIFO can accept; equals ~full
//  lu_rd       in   5   long-latency destination register
//  lu_value    in   32  long-latency result
//  rs1, rs2    in   5   decode-stage source registers, for hazard check
//  hazard_rs1  out  1   rs1 has a pending long-latency write
//  hazard_rs2  out  1   rs2 has a pending long-latency write
//  stall_req   out  1   request upstream bubble so the FIFO can drain
//  rf_wr_en    out  1   register-file write enable
//  rf_rd       out  5   register-file write address
//  rf_value    out  32  register-file write data
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FIFO empty, all entry valid bits 0, starve counter 0.
//   - stall_req=0, lu_ready=1, hazard_rs1/hazard_rs2=0, rf_wr_en=0 (held 0 while reset_n=0).
//   - Reset mid-drain discards all buffered results; no partial write.
//  Write-port select (combinational, same cycle):
//   - pipe_wr_en & pipe_rd!=0 -> rf_wr_en=1, rf_rd=pipe_rd, rf_value=pipe_value.
//   - else if FIFO non-empty and the head entry is live -> write the head, pop at edge.
//   - else if the head entry is killed -> rf_wr_en=0, pop the head anyway.
//   - else rf_wr_en=0.
//   - A pipe write with rd=0 counts as an idle slot.
//  Enqueue:
//   - Push on lu_valid & lu_ready at the clock edge.
//   - lu_rd=0 -> handshake completes but nothing is stored.
//   - No same-cycle bypass: a result is written to the register file no earlier than
//     1 cycle after acceptance.
//   - Push and pop in the same cycle are allowed when not full; count stays the same.
//   - Full -> lu_ready=0, the producer holds its data.
//   - Read/write pointers wrap modulo DEPTH.
//   - Count is CLOG2(DEPTH)+1 bits; full = (count == DEPTH).
//  WAW kill:
//   - A pipe write with pipe_rd!=0 clears the valid bit of every buffered entry whose rd
//     matches; stage-5 is younger in program order.
//   - A result accepted in the same cycle with a matching rd is stored live.
//  Hazard (combinational):
//   - hazard_rsN=1 when rsN!=0 and rsN equals the rd of any live entry.
//   - Also asserted when lu_valid=1 and lu_rd=rsN.
//  Starvation:
//   - Counter increments each cycle the FIFO is non-empty and no pop occurs.
//   - Counter clears on any pop, or when the FIFO is empty.
//   - stall_req is registered: it sets the cycle after the counter reaches STARVE_LIMIT
//     and clears the cycle after the next pop.
//   - The counter saturates at STARVE_LIMIT.
// TESTING
//  1. Reset -> stall_req=0, lu_ready=1, rf_wr_en=0; push lu_rd=5, value 0x1234 with
//     pipe idle -> rf write x5=0x1234 on the next cycle; FIFO then empty.
//  2. pipe_wr_en every cycle, rd=3; push 4 results (rd 6..9) -> lu_ready=0 after the
//     4th push; stall_req=1 after 8 non-draining cycles.
//     Then drop pipe_wr_en -> x6..x9 are written in order on consecutive cycles;
//     stall_req clears.
//  3. Buffer lu_rd=7, value 0xAAAA; pipe writes x7=0xBBBB while the entry is buffered ->
//     entry killed; final x7=0xBBBB; no later write to x7.
//  4. Buffered rd=10, rs1=10, rs2=0 -> hazard_rs1=1, hazard_rs2=0.
//     Buffered rd=0 is never stored and raises no hazard.
//  5. Full FIFO with a pop and lu_valid in the same cycle -> push refused (lu_ready=0);
//     next cycle lu_ready=1 and the push is accepted.
//     Pointer wrap verified over 3*DEPTH pushes.
//  6. reset_n low for 1 cycle with 3 entries buffered -> FIFO empty, no rf write,
//     stall_req=0 immediately.

Source files
------------

// File: rtl/writeback_port_arbiter_if.sv
// Bundles the stage-5 writeback, long-latency result handshake, decode-stage
// hazard query and register-file write port into one connection.
interface writeback_port_arbiter_if;
  logic        pipe_wr_en;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_value;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_value;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard_rs1;
  logic        hazard_rs2;
  logic        stall_req;
  logic        rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_value;

  // Drives the arbiter (pipeline, long-latency unit, decode stage).
  modport master (
    output pipe_wr_en, pipe_rd, pipe_value,
    output lu_valid, lu_rd, lu_value,
    output rs1, rs2,
    input  lu_ready, hazard_rs1, hazard_rs2, stall_req,
    input  rf_wr_en, rf_rd, rf_value
  );

  // The arbiter's own view.
  modport slave (
    input  pipe_wr_en, pipe_rd, pipe_value,
    input  lu_valid, lu_rd, lu_value,
    input  rs1, rs2,
    output lu_ready, hazard_rs1, hazard_rs2, stall_req,
    output rf_wr_en, rf_rd, rf_value
  );
endinterface

// File: rtl/writeback_port_arbiter.sv
// Shares the register-file write port between stage-5 writeback (always first)
// and a long-latency unit whose results are parked in a small FIFO and drained
// into idle writeback slots. Younger stage-5 writes kill matching buffered
// entries; live entries raise decode hazards; a starved FIFO requests a stall.
module writeback_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                      clock,
  input logic                      reset_n,
  writeback_port_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       rd_mem  [DEPTH];
  logic [31:0]      val_mem [DEPTH];
  logic [DEPTH-1:0] live_reg, live_next;
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [SW-1:0]    starve_cnt_reg, starve_cnt_next;
  logic             stall_reg;

  logic empty, full, pipe_write, pop, accept, store, head_live;
  logic [DEPTH-1:0] rs1_hit, rs2_hit;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CW'(DEPTH));
  assign pipe_write = bus.pipe_wr_en & (bus.pipe_rd != 5'd0);
  // Any slot not claimed by stage 5 retires the head, live or killed.
  assign pop        = ~empty & ~pipe_write;
  assign head_live  = live_reg[rd_ptr_reg];
  assign accept     = bus.lu_valid & ~full;
  // rd=0 results complete the handshake but are dropped.
  assign store      = accept & (bus.lu_rd != 5'd0);

  assign bus.lu_ready  = ~full;
  assign bus.stall_req = stall_reg;

  // Write-port select: stage 5 first, then a live FIFO head; forced off in reset.
  always_comb begin
    bus.rf_wr_en = 1'b0;
    bus.rf_rd    = rd_mem[rd_ptr_reg];
    bus.rf_value = val_mem[rd_ptr_reg];
    if (pipe_write) begin
      bus.rf_wr_en = reset_n;
      bus.rf_rd    = bus.pipe_rd;
      bus.rf_value = bus.pipe_value;
    end else if (pop && head_live) begin
      bus.rf_wr_en = reset_n;
    end
  end

  // Per-entry register match against the decode-stage sources.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign rs1_hit[gi] = live_reg[gi] & (rd_mem[gi] == bus.rs1);
    assign rs2_hit[gi] = live_reg[gi] & (rd_mem[gi] == bus.rs2);
  end

  assign bus.hazard_rs1 = reset_n & (bus.rs1 != 5'd0) &
                          ((|rs1_hit) | (bus.lu_valid & (bus.lu_rd == bus.rs1)));
  assign bus.hazard_rs2 = reset_n & (bus.rs2 != 5'd0) &
                          ((|rs2_hit) | (bus.lu_valid & (bus.lu_rd == bus.rs2)));

  // Live-bit update: kill on younger stage-5 write, clear on pop, set on store
  // (store comes last so a same-cycle matching result stays live).
  always_comb begin
    live_next = live_reg;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_write && (rd_mem[i] == bus.pipe_rd)) live_next[i] = 1'b0;
    end
    if (pop)   live_next[rd_ptr_reg] = 1'b0;
    if (store) live_next[wr_ptr_reg] = 1'b1;
  end

  // Starvation counter: counts non-draining cycles with data waiting, saturating.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (empty || pop)
      starve_cnt_next = '0;
    else if (starve_cnt_reg < SW'(STARVE_LIMIT))
      starve_cnt_next = starve_cnt_reg + SW'(1);
  end

  // Payload storage; only valid once the matching live bit is set, so no reset.
  always_ff @(posedge clock) begin
    if (store) begin
      rd_mem[wr_ptr_reg]  <= bus.lu_rd;
      val_mem[wr_ptr_reg] <= bus.lu_value;
    end
  end

  // Control state: pointers, occupancy, live bits, starvation and stall request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live_reg       <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      starve_cnt_reg <= '0;
      stall_reg      <= 1'b0;
    end else begin
      live_reg       <= live_next;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (store) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      count_reg      <= count_reg + CW'(store) - CW'(pop);
      starve_cnt_reg <= starve_cnt_next;
      stall_reg      <= (starve_cnt_reg == SW'(STARVE_LIMIT)) & ~pop;
    end
  end
endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Directed bench: the stimulus queues every register-file write it expects,
// a negedge monitor pops and compares each write the arbiter presents.
module tb_writeback_port_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  writeback_port_arbiter_if bus();

  writeback_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every presented write must be the next expected one.
  always @(negedge clock) begin
    if (bus.rf_wr_en !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got x%0d=%0h, expected no write (t=%0t)",
                 bus.rf_rd, bus.rf_value, $time);
      end else begin
        mon_e = exp_q.pop_front();
        $display("write x%0d=%0h (expected x%0d=%0h)", bus.rf_rd, bus.rf_value, mon_e.rd, mon_e.value);
        check("rf_rd", 32'(bus.rf_rd), 32'(mon_e.rd));
        check("rf_value", bus.rf_value, mon_e.value);
      end
    end
  end

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  // Drives one cycle of inputs and queues the stage-5 write it implies.
  task automatic drive(input logic pe, input logic [4:0] prd, input logic [31:0] pv,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lval);
    bus.pipe_wr_en = pe;
    bus.pipe_rd    = prd;
    bus.pipe_value = pv;
    bus.lu_valid   = lv;
    bus.lu_rd      = lrd;
    bus.lu_value   = lval;
    if (pe && prd != 5'd0) exp_q.push_back('{rd: prd, value: pv});
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    bus.rs1 = 5'd3;
    bus.rs2 = 5'd0;
    // Reset held: outputs quiet even with live-looking inputs.
    bus.pipe_wr_en = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_value = 32'h55;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd3; bus.lu_value = 32'h66;
    #2;
    check("reset_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
    check("reset_lu_ready", 32'(bus.lu_ready), 32'd1);
    check("reset_stall_req", 32'(bus.stall_req), 32'd0);
    check("reset_hazard_rs1", 32'(bus.hazard_rs1), 32'd0);
    bus.rs1 = 5'd0;
    idle();
    next_cycle();
    next_cycle();
    reset_n = 1'b1;

    // T1: single result, one cycle acceptance-to-write latency.
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
    check("t1_no_bypass", 32'(bus.rf_wr_en), 32'd0);
    exp_q.push_back('{rd: 5'd5, value: 32'h1234});
    next_cycle();
    idle();
    check("t1_write_en", 32'(bus.rf_wr_en), 32'd1);
    check("t1_write_rd", 32'(bus.rf_rd), 32'd5);
    next_cycle();
    idle();
    check("t1_empty_after", 32'(bus.rf_wr_en), 32'd0);

    // T2: stage 5 busy every cycle; FIFO fills, starves, then drains in order.
    for (int c = 0; c <= 10; c++) begin
      next_cycle();
      drive(1'b1, 5'd3, 32'h300 + c, c < 4, 5'(6 + c), 32'h600 + c);
      if (c < 4)  check("t2_ready_open", 32'(bus.lu_ready), 32'd1);
      if (c == 4) check("t2_ready_full", 32'(bus.lu_ready), 32'd0);
      if (c == 9) check("t2_stall_pre", 32'(bus.stall_req), 32'd0);
      if (c == 10) check("t2_stall_set", 32'(bus.stall_req), 32'd1);
    end
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      exp_q.push_back('{rd: 5'(6 + c), value: 32'h600 + c});
      idle();
      check("t2_drain_en", 32'(bus.rf_wr_en), 32'd1);
      if (c == 0) check("t2_stall_hold", 32'(bus.stall_req), 32'd1);
      if (c == 1) check("t2_stall_clear", 32'(bus.stall_req), 32'd0);
    end
    next_cycle();
    idle();
    check("t2_drained", 32'(bus.rf_wr_en), 32'd0);

    // T3: buffered x7 killed by a younger stage-5 write to x7.
    next_cycle();
    drive(1'b1, 5'd3, 32'h31, 1'b1, 5'd7, 32'hAAAA);
    next_cycle();
    drive(1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, 32'h0);
    next_cycle();
    idle();
    check("t3_killed_no_write", 32'(bus.rf_wr_en), 32'd0);
    next_cycle();
    idle();
    check("t3_empty", 32'(bus.rf_wr_en), 32'd0);

    // T4: hazards against an in-flight and a buffered result; rd=0 is dropped.
    next_cycle();
    bus.rs1 = 5'd10; bus.rs2 = 5'd0;
    drive(1'b1, 5'd3, 32'h41, 1'b1, 5'd10, 32'hA10);
    check("t4_hazard_inflight", 32'(bus.hazard_rs1), 32'd1);
    next_cycle();
    drive(1'b1, 5'd3, 32'h42, 1'b0, 5'd0, 32'h0);
    check("t4_hazard_rs1", 32'(bus.hazard_rs1), 32'd1);
    check("t4_hazard_rs2_zero", 32'(bus.hazard_rs2), 32'd0);
    bus.rs1 = 5'd11; bus.rs2 = 5'd10;
    #1;
    check("t4_hazard_rs1_miss", 32'(bus.hazard_rs1), 32'd0);
    check("t4_hazard_rs2_hit", 32'(bus.hazard_rs2), 32'd1);
    next_cycle();
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    drive(1'b1, 5'd3, 32'h43, 1'b1, 5'd0, 32'hDEAD);
    check("t4_rd0_ready", 32'(bus.lu_ready), 32'd1);
    next_cycle();
    exp_q.push_back('{rd: 5'd10, value: 32'hA10});
    idle();
    check("t4_drain_x10", 32'(bus.rf_rd), 32'd10);
    next_cycle();
    idle();
    check("t4_rd0_not_stored", 32'(bus.rf_wr_en), 32'd0);

    // T5: full FIFO refuses a push during a pop, accepts it the next cycle.
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      drive(1'b1, 5'd3, 32'h500 + c, 1'b1, 5'(12 + c), 32'hC00 + c);
    end
    next_cycle();
    for (int c = 0; c < 5; c++) exp_q.push_back('{rd: 5'(12 + c), value: 32'hC00 + c});
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 32'hC04);
    check("t5_full_refuse", 32'(bus.lu_ready), 32'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 32'hC04);
    check("t5_accept_after_pop", 32'(bus.lu_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      idle();
    end
    check("t5_drained", 32'(bus.rf_wr_en), 32'd0);
    // Streaming pushes with immediate drains wrap both pointers several times.
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(17 + c), 32'hE00 + c);
      exp_q.push_back('{rd: 5'(17 + c), value: 32'hE00 + c});
    end
    next_cycle();
    idle();
    next_cycle();
    idle();
    check("t5_wrap_drained", 32'(bus.rf_wr_en), 32'd0);

    // T6: reset with three buffered entries discards them.
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      drive(1'b1, 5'd3, 32'h600 + c, 1'b1, 5'(20 + c), 32'hF00 + c);
    end
    next_cycle();
    bus.rs1 = 5'd20;
    reset_n = 1'b0;
    idle();
    check("t6_rst_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
    check("t6_rst_stall", 32'(bus.stall_req), 32'd0);
    check("t6_rst_ready", 32'(bus.lu_ready), 32'd1);
    check("t6_rst_hazard", 32'(bus.hazard_rs1), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    #1;
    check("t6_post_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
    check("t6_post_hazard", 32'(bus.hazard_rs1), 32'd0);
    next_cycle();
    idle();
    check("t6_post2_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
    bus.rs1 = 5'd0;

    // Bounded wait for the scoreboard to empty.
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) next_cycle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
